// File: rtl/seq_chunk_adder_pkg.sv
// Shared definitions for the chunk-serial adder: FSM state encoding and default sizing.
package seq_chunk_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CHUNK = 8;

endpackage

// File: rtl/seq_chunk_adder_rca.sv
// Combinational CHUNK-bit ripple-carry adder built from per-bit full adders.
module rca_chunk
  import seq_chunk_adder_pkg::*;
#(
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb_in
);

  logic [CHUNK:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int unsigned i = 0; i < CHUNK; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign co       = c[CHUNK];
  assign c_msb_in = c[CHUNK-1];

endmodule

// File: rtl/seq_chunk_adder.sv
// Chunk-serial adder/subtractor: one CHUNK-bit ripple adder reused LSB-first over NCH cycles.
module seq_chunk_adder
  import seq_chunk_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IW-1:0] LAST = IW'(NCH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] bp_r;
  logic             carry;
  logic [IW-1:0]    idx;

  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK-1:0] s_chunk;
  logic             co;
  logic             c_msb;

  // Chunk i of the captured operands feeds the single shared adder.
  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (idx == IW'(i)) begin
        a_chunk = a_r[i*CHUNK +: CHUNK];
        b_chunk = bp_r[i*CHUNK +: CHUNK];
      end
    end
  end

  rca_chunk #(
    .CHUNK (CHUNK)
  ) u_rca (
    .a        (a_chunk),
    .b        (b_chunk),
    .ci       (carry),
    .s        (s_chunk),
    .co       (co),
    .c_msb_in (c_msb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_r   <= '0;
      bp_r  <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r   <= a;
            bp_r  <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            idx   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            state <= RUN;
          end
        end
        RUN: begin
          for (int unsigned i = 0; i < NCH; i++) begin
            if (idx == IW'(i)) sum[i*CHUNK +: CHUNK] <= s_chunk;
          end
          carry <= co;
          // Index parks on the last chunk instead of wrapping when NCH is a power of two.
          if (idx == LAST) begin
            cout  <= co;
            ovf   <= co ^ c_msb;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Directed self-checking bench for seq_chunk_adder at WIDTH=16, CHUNK=4.
module tb_seq_chunk_adder;

  localparam int W = 16;
  localparam int C = 4;
  localparam int N = W / C;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int n_cmp = 0;
  int n_bad = 0;

  seq_chunk_adder #(
    .WIDTH (W),
    .CHUNK (C)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference arithmetic: returns {ovf, cout, sum}.
  function automatic logic [W+1:0] ref_result(input logic [W-1:0] x, input logic [W-1:0] y,
                                              input logic ci, input logic sb);
    logic [W:0] full;
    logic       v;
    if (sb) begin
      full[W-1:0] = x - y;
      full[W]     = (x >= y);
      v = (x[W-1] != y[W-1]) && (full[W-1] != x[W-1]);
    end else begin
      full = {1'b0, x} + {1'b0, y} + (W+1)'(ci);
      v = (x[W-1] == y[W-1]) && (full[W-1] != x[W-1]);
    end
    return {v, full};
  endfunction

  // Transaction-level model: busy from acceptance until hand-off, result due N edges later.
  bit           mdl_busy = 1'b0;
  int           edges = 0;
  int           mdl_due = 0;
  logic [W+1:0] mdl_res = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdl_busy = 1'b0;
    end else begin
      if (!mdl_busy && in_valid) begin
        mdl_busy = 1'b1;
        mdl_due  = edges + N + 1;
        mdl_res  = ref_result(a, b, cin, sub);
      end else if (mdl_busy && edges >= mdl_due && out_ready) begin
        mdl_busy = 1'b0;
      end
      edges++;
    end
  end

  always @(negedge clk) begin
    bit exp_v;
    exp_v = mdl_busy && (edges >= mdl_due);
    chk("in_ready", 32'(in_ready), 32'(!mdl_busy));
    chk("out_valid", 32'(out_valid), 32'(exp_v));
    if (exp_v) begin
      chk("model_sum", 32'(sum), 32'(mdl_res[W-1:0]));
      chk("model_cout", 32'(cout), 32'(mdl_res[W]));
      chk("model_ovf", 32'(ovf), 32'(mdl_res[W+1]));
    end
    if (!rst_n) begin
      chk("rst_sum", 32'(sum), 0);
      chk("rst_cout", 32'(cout), 0);
      chk("rst_ovf", 32'(ovf), 0);
    end
  end

  task automatic run_txn(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tcin,
                         input logic tsub, input logic [W-1:0] es, input logic ec,
                         input logic eo, input int hold, input bit disturb);
    int t;
    int lat;
    @(negedge clk);
    a = ta; b = tb; cin = tcin; sub = tsub; in_valid = 1'b1; out_ready = 1'b0;
    t = 0;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("accept_timeout", 32'(t < 20), 1);
    @(negedge clk);
    in_valid = 1'b0; a = ~ta; b = ta ^ 16'h5a5a; cin = ~tcin; sub = ~tsub;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
      if (disturb) begin
        in_valid = lat[0];
        a = 16'($urandom);
        b = 16'($urandom);
      end
    end
    in_valid = 1'b0;
    chk("latency", 32'(lat), N);
    chk("lit_sum", 32'(sum), 32'(es));
    chk("lit_cout", 32'(cout), 32'(ec));
    chk("lit_ovf", 32'(ovf), 32'(eo));
    repeat (hold) begin
      @(negedge clk);
      chk("hold_valid", 32'(out_valid), 1);
      chk("hold_in_ready", 32'(in_ready), 0);
      chk("hold_sum", 32'(sum), 32'(es));
      chk("hold_cout", 32'(cout), 32'(ec));
      chk("hold_ovf", 32'(ovf), 32'(eo));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("handoff_valid", 32'(out_valid), 0);
    chk("handoff_in_ready", 32'(in_ready), 1);
  endtask

  task automatic run_abort(input logic [W-1:0] ta, input logic [W-1:0] tb);
    @(negedge clk);
    a = ta; b = tb; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_in_ready", 32'(in_ready), 1);
    chk("abort_out_valid", 32'(out_valid), 0);
    chk("abort_sum", 32'(sum), 0);
    chk("abort_cout", 32'(cout), 0);
    chk("abort_ovf", 32'(ovf), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("abort_no_pulse", 32'(out_valid), 0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("reset_in_ready", 32'(in_ready), 1);
    chk("reset_out_valid", 32'(out_valid), 0);
    rst_n = 1'b1;

    run_txn(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 0, 1'b0);
    run_txn(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 0, 1'b0);
    run_txn(16'h1234, 16'h1111, 1'b1, 1'b0, 16'h2346, 1'b0, 1'b0, 3, 1'b0);
    run_txn(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 0, 1'b0);
    run_txn(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1, 1'b1);
    run_txn(16'h9ABC, 16'h1234, 1'b0, 1'b1, 16'h8888, 1'b1, 1'b0, 0, 1'b1);
    run_abort(16'h1234, 16'h1111);
    run_txn(16'h1234, 16'h1111, 1'b1, 1'b0, 16'h2346, 1'b0, 1'b0, 0, 1'b0);
    run_txn(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 0, 1'b0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_chunk_adder.md
SEQ_CHUNK_ADDER -- requirements
Module: seq_chunk_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32: operand/result width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 8: bits added per cycle; WIDTH SHALL be an integer multiple of CHUNK, and NCH = WIDTH/CHUNK.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: operands presented.
REQ-006 The block SHALL have port in_ready, output, 1 bit: block can accept operands.
REQ-007 The block SHALL have port a, input, WIDTH bits: operand A.
REQ-008 The block SHALL have port b, input, WIDTH bits: operand B.
REQ-009 The block SHALL have port cin, input, 1 bit: carry-in, used in add mode only.
REQ-010 The block SHALL have port sub, input, 1 bit: 0 = A+B+cin, 1 = A-B.
REQ-011 The block SHALL have port out_valid, output, 1 bit: result available.
REQ-012 The block SHALL have port out_ready, input, 1 bit: consumer accepts result.
REQ-013 The block SHALL have port sum, output, WIDTH bits: result.
REQ-014 The block SHALL have port cout, output, 1 bit: final carry out of the MSB.
REQ-015 The block SHALL have port ovf, output, 1 bit: signed two's-complement overflow.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-017 in_ready SHALL equal 1 only in IDLE, and out_valid SHALL equal 1 only in DONE.
REQ-018 Acceptance SHALL occur on a rising edge where in_valid=1 and in_ready=1.
REQ-019 On acceptance the block SHALL capture a, b and sub; it SHALL capture B' = sub ? ~b : b; it SHALL load the carry register with sub ? 1 : cin; it SHALL clear the chunk index; and the FSM SHALL move IDLE->RUN.
REQ-020 In RUN, each edge SHALL add chunk i of A, chunk i of B' and the carry register, chunks taken LSB-first.
REQ-021 Each RUN edge SHALL write the CHUNK-bit result into sum chunk i and update the carry register.
REQ-022 Each RUN edge SHALL increment i.
REQ-023 After chunk NCH-1 the FSM SHALL move RUN->DONE.
REQ-024 The latency SHALL be exactly NCH cycles: out_valid SHALL rise NCH rising edges after the acceptance edge.
REQ-025 With CHUNK=WIDTH, out_valid SHALL rise 1 cycle after acceptance.
REQ-026 In DONE, cout SHALL equal the final carry out of the MSB.
REQ-027 In DONE, ovf SHALL equal the carry into the MSB XOR the carry out of the MSB.
REQ-028 In subtract mode, cout SHALL equal 1 when A >= B unsigned (no borrow).
REQ-029 sum, cout and ovf SHALL hold stable while out_valid=1.
REQ-030 DONE->IDLE SHALL occur on an edge with out_ready=1.
REQ-031 out_ready=0 SHALL hold DONE indefinitely with outputs unchanged.
REQ-032 in_valid SHALL be ignored in RUN and DONE.
REQ-033 Inputs a, b, cin and sub SHALL be don't-care after acceptance; changes to them SHALL NOT affect the result in flight.
REQ-034 The block SHALL NOT take a new operand in the same cycle it hands off a result; in_ready SHALL rise the cycle after the DONE->IDLE edge.
REQ-035 The chunk index SHALL be ceil(log2(NCH)) bits wide, minimum 1 bit.
REQ-036 The chunk index SHALL NOT wrap within a RUN.
REQ-037 sum, cout and ovf SHALL be registered outputs, driven directly from state and not combinationally from inputs.

Reset
REQ-038 While rst_n=0 the FSM SHALL be in IDLE, independent of clk.
REQ-039 While rst_n=0, in_ready SHALL be 1 and out_valid SHALL be 0.
REQ-040 While rst_n=0, sum, the carry register, cout, ovf and the chunk index SHALL be 0.
REQ-041 Reset asserted mid-RUN or in DONE SHALL abort the operation with no output pulse.
REQ-042 The first acceptance after reset deassertion SHALL behave as from power-up.

Structure
REQ-043 A shared package SHALL hold the FSM state enum (IDLE/RUN/DONE).
REQ-044 The shared package SHALL hold the default parameter constants.
REQ-045 The block SHALL contain exactly one sub-module, rca_chunk: a combinational CHUNK-bit ripple-carry adder built from per-bit full-adder logic.
REQ-046 rca_chunk SHALL have inputs a[CHUNK], b[CHUNK] and ci, and outputs s[CHUNK], co and c_msb_in (carry into the top bit).
REQ-047 seq_chunk_adder SHALL instantiate one rca_chunk and reuse it every RUN cycle.

Verification
The bench SHALL use WIDTH=16, CHUNK=4 (NCH=4).
REQ-048 Add 0xFFFF+0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0, with out_valid rising exactly 4 cycles after acceptance.
REQ-049 Add 0x7FFF+0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1; add 0x1234+0x1111, cin=1 -> sum=0x2346, cout=0, ovf=0.
REQ-050 Subtract 0x0005-0x0007 -> sum=0xFFFE, cout=0, ovf=0; subtract 0x8000-0x0001 -> sum=0x7FFF, cout=1, ovf=1.
REQ-051 Hold out_ready=0 for 3 cycles in DONE -> out_valid stays 1 and sum/cout/ovf stay constant; in_ready stays 0; IDLE follows the first edge with out_ready=1.
REQ-052 Toggle in_valid with new a and b during RUN -> the result is unaffected and no extra transaction occurs.
REQ-053 Assert rst_n=0 after 2 RUN cycles -> outputs are immediately at reset values, with no out_valid pulse; the next transaction is correct.
